// File: rtl/div_pkg.sv
// Shared types and constants for the sequential
// radix-2 restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam int          DIV_W      = 32;
  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/div_seq32_if.sv
// Request/response bundle between the execute
// stage controller and the divider.
interface div_seq32_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start,
    output is_signed,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_zero
  );

  modport slave (
    input  start,
    input  is_signed,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the
// next dividend bit and subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;

  // rem < dsr always holds, so the shift never
  // loses a significant bit.
  assign sh   = {rem[WIDTH-1:0], bit_in};
  assign diff = {1'b0, sh} - {2'b00, dsr};
  assign qbit = ~diff[WIDTH+1];

  assign rem_nxt = qbit ? diff[WIDTH:0] : sh;

endmodule

// File: rtl/div_seq32.sv
// Multi-cycle 32-bit signed/unsigned divider,
// one quotient bit per clock, results to HI/LO.
module div_seq32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic         clk,
  input logic         rst_n,
  div_seq32_if.slave  bus
);

  state_t           state;
  logic [4:0]       cnt;
  logic             sgn;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q_o;
  logic [WIDTH-1:0] r_o;
  logic             z_o;

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   rem_nxt;
  logic             qbit;

  assign a_neg_c = sgn & a_raw[WIDTH-1];
  assign b_neg_c = sgn & b_raw[WIDTH-1];
  assign a_mag_c = a_neg_c ? -a_raw : a_raw;
  assign b_mag_c = b_neg_c ? -b_raw : b_raw;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (rem),
    .bit_in  (q_sh[WIDTH-1]),
    .dsr     (b_mag),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sgn   <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      a_raw <= '0;
      b_raw <= '0;
      b_mag <= '0;
      q_sh  <= '0;
      rem   <= '0;
      q_o   <= '0;
      r_o   <= '0;
      z_o   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            a_raw <= bus.dividend;
            b_raw <= bus.divisor;
            sgn   <= bus.is_signed;
            state <= PREP;
          end
        end
        (state == PREP): begin
          neg_a <= a_neg_c;
          neg_b <= b_neg_c;
          b_mag <= b_mag_c;
          if (b_raw == '0) begin
            q_o   <= WIDTH'(DIV_ZERO_Q);
            r_o   <= a_raw;
            z_o   <= 1'b1;
            state <= DONE;
          end else begin
            rem   <= '0;
            q_sh  <= a_mag_c;
            cnt   <= '0;
            state <= ITER;
          end
        end
        (state == ITER): begin
          rem  <= rem_nxt;
          q_sh <= {q_sh[WIDTH-2:0], qbit};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITERS - 1))
            state <= FIX;
        end
        (state == FIX): begin
          // Truncation toward zero; remainder
          // follows the dividend's sign.
          q_o   <= (neg_a ^ neg_b) ? -q_sh : q_sh;
          r_o   <= neg_a ? -rem[WIDTH-1:0]
                         : rem[WIDTH-1:0];
          z_o   <= 1'b0;
          state <= DONE;
        end
        (state == DONE): begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = q_o;
  assign bus.remainder = r_o;
  assign bus.div_zero  = z_o;

endmodule

// File: tb/tb_div_seq32.sv
// Randomized self-checking bench for div_seq32
// against an arithmetic reference model.
module tb_div_seq32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  div_seq32_if #(.WIDTH(32)) bus ();

  div_seq32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        z
  );
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  function automatic logic [63:0] busy_exp(
    input int last
  );
    logic [63:0] m;
    m = '0;
    for (int i = 1; i <= last; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Starts one op in cycle 0, scrambles inputs
  // afterwards, optionally re-pulses start, and
  // stops two cycles after the first done.
  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    input  int          rp1,
    input  int          rp2,
    output int          done_cyc,
    output int          n_done,
    output logic [63:0] busy_bits
  );
    done_cyc  = -1;
    n_done    = 0;
    busy_bits = '0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.start     = (c == rp1) || (c == rp2);
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      busy_bits[c]  = bus.busy;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2)
        break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_zero,
         bus.quotient, bus.remainder} !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b z=%b q=%h r=%h want all 0",
               bus.busy, bus.done, bus.div_zero,
               bus.quotient, bus.remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_one(
    input string       name,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic [31:0] eq,
    input logic [31:0] er,
    input logic        ez
  );
    int dc, nd;
    logic [63:0] bb;
    int edc;
    edc = (b == 0) ? 2 : 35;
    run_op(a, b, s, -1, -1, dc, nd, bb);
    checks++;
    if (bus.quotient !== eq || bus.remainder !== er ||
        bus.div_zero !== ez) begin
      failures++;
      $display("FAIL %s: q=%h r=%h z=%b want q=%h r=%h z=%b",
               name, bus.quotient, bus.remainder,
               bus.div_zero, eq, er, ez);
    end
    checks++;
    if (dc != edc || nd != 1) begin
      failures++;
      $display("FAIL %s_latency: done_cyc=%0d n=%0d want %0d n=1",
               name, dc, nd, edc);
    end
    checks++;
    if (bb !== busy_exp(edc)) begin
      failures++;
      $display("FAIL %s_busy: got %h want %h",
               name, bb, busy_exp(edc));
    end
  endtask

  task automatic test_directed;
    test_one("u100_7", 32'd100, 32'd7, 1'b0,
             32'd14, 32'd2, 1'b0);
    test_one("s-7_2", -32'sd7, 32'd2, 1'b1,
             32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    test_one("s7_-2", 32'd7, -32'sd2, 1'b1,
             32'hFFFFFFFD, 32'd1, 1'b0);
    test_one("div0", 32'h1234, 32'd0, 1'b0,
             32'hFFFFFFFF, 32'h1234, 1'b1);
    test_one("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0,
             32'hFFFFFFFF, 32'd0, 1'b0);
    test_one("smin_-1", 32'h80000000, 32'hFFFFFFFF,
             1'b1, 32'h80000000, 32'd0, 1'b0);
    test_one("u_big", 32'hFFFFFFFF, 32'hFFFFFFFE,
             1'b0, 32'd1, 32'd1, 1'b0);
  endtask

  task automatic test_ignore_start;
    int dc, nd;
    logic [63:0] bb;
    run_op(32'd1000, 32'd9, 1'b0, 5, 35, dc, nd, bb);
    checks++;
    if (bus.quotient !== 32'd111 ||
        bus.remainder !== 32'd1) begin
      failures++;
      $display("FAIL ignore_result: q=%h r=%h want q=6f r=1",
               bus.quotient, bus.remainder);
    end
    checks++;
    if (dc != 35 || nd != 1 || bb !== busy_exp(35)) begin
      failures++;
      $display("FAIL ignore_done: dc=%0d n=%0d busy=%h want 35 1 %h",
               dc, nd, bb, busy_exp(35));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle: busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid;
    int dc, nd;
    logic [63:0] bb;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd5000;
    bus.divisor  = 32'd3;
    bus.is_signed = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero,
         bus.quotient, bus.remainder} !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b z=%b q=%h r=%h want all 0",
               bus.busy, bus.done, bus.div_zero,
               bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd5000, 32'd3, 1'b0, -1, -1, dc, nd, bb);
    checks++;
    if (bus.quotient !== 32'd1666 ||
        bus.remainder !== 32'd2 || dc != 35) begin
      failures++;
      $display("FAIL reset_rerun: q=%h r=%h dc=%0d want 682 2 35",
               bus.quotient, bus.remainder, dc);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er;
    logic s, ez;
    int dc, nd, edc;
    logic [63:0] bb;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = -($urandom_range(1, 20));
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      model(a, b, s, eq, er, ez);
      edc = (b == 0) ? 2 : 35;
      run_op(a, b, s, -1, -1, dc, nd, bb);
      checks++;
      if (bus.quotient !== eq || bus.remainder !== er ||
          bus.div_zero !== ez || dc != edc || nd != 1) begin
        failures++;
        $display("FAIL rand%0d: a=%h b=%h s=%b q=%h r=%h z=%b dc=%0d want q=%h r=%h z=%b dc=%0d",
                 i, a, b, s, bus.quotient, bus.remainder,
                 bus.div_zero, dc, eq, er, ez, edc);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
